// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - registered, handshaked immediate-decode stage with 2-entry skid buffer

package rvcpu;
    typedef enum logic [3:0] {
        alu_imm      = 4'd0,
        load_offset  = 4'd1,
        store_offset = 4'd2,
        uimm         = 4'd3,
        jalr_offset  = 4'd4,
        br_offset    = 4'd5,
        jal_offset   = 4'd6,
        upper_imm    = 4'd7,
        shamt        = 4'd8
    } imm_type_t;
endpackage

module imm_decode_stage #(
    parameter int Width = 32,
    parameter bit HasC  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_op,
    input  logic [Width-1:0]  in_pc,
    input  rvcpu::imm_type_t  in_immtype,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [Width-1:0]  out_imm,
    output logic [Width-1:0]  out_target,
    output logic              out_misaligned,
    output logic [Width-1:0]  out_pc
);

    // Decoded payload of the instruction currently presented upstream
    logic [Width-1:0] d_imm;
    logic [Width-1:0] d_target;
    logic [Width-1:0] d_sum;
    logic             d_mis;
    logic             d_use_target;
    logic             d_branch;
    logic [5:0]       d_shamt;

    // Main output register M
    logic             m_valid;
    logic [Width-1:0] m_imm;
    logic [Width-1:0] m_target;
    logic             m_mis;
    logic [Width-1:0] m_pc;

    // Skid register S, only filled while M is stalled
    logic             s_valid;
    logic [Width-1:0] s_imm;
    logic [Width-1:0] s_target;
    logic             s_mis;
    logic [Width-1:0] s_pc;

    logic             in_ready_q;
    logic             accept;
    logic             drain;

    // Opcode field is never needed: the immediate kind arrives pre-decoded
    logic             unused_opcode;
    assign unused_opcode = ^in_op[6:0];

    // RV64 shift amounts carry one extra bit
    assign d_shamt = (Width == 64) ? in_op[25:20] : {1'b0, in_op[24:20]};

    // Extract and extend the immediate for the presented kind
    always_comb begin
        d_imm        = '0;
        d_use_target = 1'b0;
        d_branch     = 1'b0;
        case (in_immtype)
            rvcpu::alu_imm, rvcpu::load_offset, rvcpu::jalr_offset: begin
                d_imm = Width'($signed(in_op[31:20]));
            end
            rvcpu::store_offset: begin
                d_imm = Width'($signed({in_op[31:25], in_op[11:7]}));
            end
            rvcpu::br_offset: begin
                d_imm        = Width'($signed({in_op[31], in_op[7], in_op[30:25],
                                               in_op[11:8], 1'b0}));
                d_use_target = 1'b1;
                d_branch     = 1'b1;
            end
            rvcpu::jal_offset: begin
                d_imm        = Width'($signed({in_op[31], in_op[19:12], in_op[20],
                                               in_op[30:21], 1'b0}));
                d_use_target = 1'b1;
                d_branch     = 1'b1;
            end
            rvcpu::upper_imm: begin
                d_imm        = Width'($signed({in_op[31:12], 12'b0}));
                d_use_target = 1'b1;
            end
            rvcpu::uimm: begin
                d_imm = Width'(in_op[19:15]);
            end
            rvcpu::shamt: begin
                d_imm = Width'(d_shamt);
            end
            default: begin
                d_imm = '0;
            end
        endcase
    end

    // PC-relative target wraps modulo 2^Width; only control-flow targets flag misalignment
    assign d_sum    = in_pc + d_imm;
    assign d_target = d_use_target ? d_sum : '0;
    assign d_mis    = (HasC == 1'b0) && d_branch && d_target[1];

    assign accept = in_valid && in_ready_q;
    assign drain  = m_valid && out_ready;

    // M/S skid buffer; in_ready is registered as the complement of next S.valid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid    <= 1'b0;
            m_imm      <= '0;
            m_target   <= '0;
            m_mis      <= 1'b0;
            m_pc       <= '0;
            s_valid    <= 1'b0;
            s_imm      <= '0;
            s_target   <= '0;
            s_mis      <= 1'b0;
            s_pc       <= '0;
            in_ready_q <= 1'b0;
        end else begin
            if (drain && s_valid) begin
                // S refills M; upstream is blocked so no accept can coincide
                m_valid    <= 1'b1;
                m_imm      <= s_imm;
                m_target   <= s_target;
                m_mis      <= s_mis;
                m_pc       <= s_pc;
                s_valid    <= 1'b0;
                in_ready_q <= 1'b1;
            end else if (accept && (!m_valid || drain)) begin
                m_valid    <= 1'b1;
                m_imm      <= d_imm;
                m_target   <= d_target;
                m_mis      <= d_mis;
                m_pc       <= in_pc;
                in_ready_q <= 1'b1;
            end else if (accept) begin
                // M is full and stalled: park the newcomer in S
                s_valid    <= 1'b1;
                s_imm      <= d_imm;
                s_target   <= d_target;
                s_mis      <= d_mis;
                s_pc       <= in_pc;
                in_ready_q <= 1'b0;
            end else begin
                if (drain) begin
                    m_valid <= 1'b0;
                end
                in_ready_q <= !s_valid;
            end
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = m_valid;
    assign out_imm        = m_imm;
    assign out_target     = m_target;
    assign out_misaligned = m_mis;
    assign out_pc         = m_pc;

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb/tb_imm_decode_stage.sv - directed-vector bench for imm_decode_stage

module tb_imm_decode_stage;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             out_ready;
    logic [31:0]      in_op;
    logic [63:0]      pc64;
    rvcpu::imm_type_t in_immtype;

    logic             rdy32, rdy64, rdync;
    logic             ov32, ov64, ovnc;
    logic [31:0]      imm32, tgt32, pco32;
    logic [63:0]      imm64, tgt64, pco64;
    logic [31:0]      immnc, tgtnc, pconc;
    logic             mis32, mis64, misnc;

    int n_checks;
    int n_fail;

    logic [63:0] rx[$];
    logic [31:0] stream_ops[4];

    imm_decode_stage #(.Width(32), .HasC(1'b1)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
        .in_op(in_op), .in_pc(pc64[31:0]), .in_immtype(in_immtype),
        .out_valid(ov32), .out_ready(out_ready), .out_imm(imm32),
        .out_target(tgt32), .out_misaligned(mis32), .out_pc(pco32)
    );

    imm_decode_stage #(.Width(64), .HasC(1'b1)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64),
        .in_op(in_op), .in_pc(pc64), .in_immtype(in_immtype),
        .out_valid(ov64), .out_ready(out_ready), .out_imm(imm64),
        .out_target(tgt64), .out_misaligned(mis64), .out_pc(pco64)
    );

    imm_decode_stage #(.Width(32), .HasC(1'b0)) dutnc (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdync),
        .in_op(in_op), .in_pc(pc64[31:0]), .in_immtype(in_immtype),
        .out_valid(ovnc), .out_ready(out_ready), .out_imm(immnc),
        .out_target(tgtnc), .out_misaligned(misnc), .out_pc(pconc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one instruction at a negedge; it is accepted at the next posedge
    // and the outputs are sampled at the following negedge.
    task automatic run_vec(input logic [31:0] op, input logic [63:0] pc, input rvcpu::imm_type_t t);
        in_op      = op;
        pc64       = pc;
        in_immtype = t;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        @(negedge clk);
        in_valid   = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        in_op      = 32'h0;
        pc64       = 64'h0;
        in_immtype = rvcpu::alu_imm;
        stream_ops[0] = 32'h00100093;
        stream_ops[1] = 32'h00200093;
        stream_ops[2] = 32'h00300093;
        stream_ops[3] = 32'h00400093;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {63'd0, ov32}, 64'd0);
        check("rst_in_ready",  {63'd0, rdy32}, 64'd0);
        check("rst_imm",       {32'd0, imm32}, 64'd0);
        check("rst_target",    tgt64, 64'd0);
        check("rst_pc",        {32'd0, pco32}, 64'd0);
        check("rst_mis",       {63'd0, misnc}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", {63'd0, rdy32}, 64'd1);
        check("post_rst_out_valid", {63'd0, ov32}, 64'd0);

        run_vec(32'hFFF00093, 64'h0, rvcpu::alu_imm);
        check("alu_valid",   {63'd0, ov32}, 64'd1);
        check("alu_imm32",   {32'd0, imm32}, 64'h00000000FFFFFFFF);
        check("alu_imm64",   imm64, 64'hFFFFFFFFFFFFFFFF);
        check("alu_target",  {32'd0, tgt32}, 64'd0);
        check("alu_mis",     {63'd0, misnc}, 64'd0);

        run_vec(32'h0080006F, 64'h100, rvcpu::jal_offset);
        check("jal_imm",     {32'd0, imm32}, 64'h8);
        check("jal_target",  {32'd0, tgt32}, 64'h108);
        check("jal_pc",      {32'd0, pco32}, 64'h100);
        check("jal_mis_nc",  {63'd0, misnc}, 64'd0);

        run_vec(32'hFE000EE3, 64'h200, rvcpu::br_offset);
        check("br_imm",      {32'd0, imm32}, 64'hFFFFFFFC);
        check("br_target",   {32'd0, tgt32}, 64'h1FC);
        check("br_target64", tgt64, 64'h1FC);
        check("br_mis_nc",   {63'd0, misnc}, 64'd0);

        run_vec(32'h800000B7, 64'h1000, rvcpu::upper_imm);
        check("lui_imm64",   imm64, 64'hFFFFFFFF80000000);
        check("lui_tgt64",   tgt64, 64'hFFFFFFFF80001000);
        check("lui_imm32",   {32'd0, imm32}, 64'h80000000);
        check("lui_tgt32",   {32'd0, tgt32}, 64'h80001000);

        run_vec(32'h03F09093, 64'h40, rvcpu::shamt);
        check("shamt64",     imm64, 64'd63);
        check("shamt32",     {32'd0, imm32}, 64'd31);
        check("shamt_tgt",   tgt64, 64'd0);

        run_vec(32'h0020006F, 64'h100, rvcpu::jal_offset);
        check("jal2_target", {32'd0, tgtnc}, 64'h102);
        check("jal2_mis_nc", {63'd0, misnc}, 64'd1);
        check("jal2_mis_c",  {63'd0, mis32}, 64'd0);

        run_vec(32'hFE112C23, 64'h80, rvcpu::store_offset);
        check("store_imm",   {32'd0, imm32}, 64'hFFFFFFF8);
        check("store_tgt",   {32'd0, tgt32}, 64'd0);

        run_vec(32'hFFFF8073, 64'h0, rvcpu::uimm);
        check("uimm_imm",    imm64, 64'd31);

        run_vec(32'hFFFFFFFF, 64'h300, rvcpu::imm_type_t'(4'd15));
        check("bad_imm",     imm64, 64'd0);
        check("bad_target",  tgt64, 64'd0);
        check("bad_mis",     {63'd0, misnc}, 64'd0);

        // Drain the last vector so the buffer starts empty
        out_ready = 1'b1;
        @(negedge clk);
        check("idle_valid",  {63'd0, ov32}, 64'd0);

        // Back-pressure stream A..D with out_ready low for three cycles
        begin
            int idx;
            idx = 0;
            for (int c = 0; c < 12; c++) begin
                out_ready = (c >= 3);
                in_valid  = (idx < 4);
                in_op     = (idx < 4) ? stream_ops[idx] : 32'h0;
                pc64      = 64'h1000 + 64'(idx * 4);
                in_immtype = rvcpu::alu_imm;
                if (c == 2) begin
                    check("bp_in_ready_low", {63'd0, rdy32}, 64'd0);
                    check("bp_m_holds_a",    {32'd0, imm32}, 64'd1);
                    check("bp_valid",        {63'd0, ov32}, 64'd1);
                end
                if (ov32 && out_ready) rx.push_back({32'd0, imm32});
                if (in_valid && rdy32) idx++;
                @(negedge clk);
            end
            in_valid = 1'b0;
            check("bp_count", 64'(rx.size()), 64'd4);
            for (int i = 0; i < 4; i++) begin
                check("bp_order", (i < rx.size()) ? rx[i] : 64'hDEAD, 64'(i + 1));
            end
        end

        // Fill M and S, then reset mid-stream
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_op      = 32'h00500093;
        @(negedge clk);
        in_op      = 32'h00600093;
        @(negedge clk);
        in_valid   = 1'b0;
        check("pre_rst_full", {63'd0, rdy32}, 64'd0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_valid", {63'd0, ov32}, 64'd0);
        check("midrst_imm",   {32'd0, imm32}, 64'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("midrst_ready", {63'd0, rdy32}, 64'd1);
        repeat (3) @(negedge clk);
        check("midrst_no_replay", {63'd0, ov32}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Registered, handshaked immediate-decode stage for the rvcpu decode path, sitting between instruction fetch/decode and the issue/execute boundary. It generalises combinational immediate extraction in three ways: XLEN via `Width`, added immediate kinds (`upper_imm`, `shamt`), and a precomputed PC-relative target with misalignment flagging. It decouples upstream and downstream through a valid/ready interface with a 2-entry skid buffer, so it sustains one instruction per cycle with no combinational ready path.

## Interface
- `Width`, 32, datapath width; legal values 32 or 64.
- `HasC`, 1, compressed-ISA support. When 0, targets that are not 4-byte aligned are flagged.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  upstream holds a valid instruction.
- `in_ready`  out  1  stage can accept; a transfer occurs when `in_valid && in_ready`.
- `in_op`  in  32  raw instruction word.
- `in_pc`  in  Width  PC of `in_op`.
- `in_immtype`  in  rvcpu::imm_type_t  immediate kind. The enum carries `alu_imm`, `load_offset`, `store_offset`, `uimm`, `jalr_offset`, `br_offset`, `jal_offset`, `upper_imm` and `shamt`.
- `out_valid`  out  1  output payload valid.
- `out_ready`  in  1  downstream accepts; a transfer occurs when `out_valid && out_ready`.
- `out_imm`  out  Width  decoded immediate.
- `out_target`  out  Width  `pc + imm` for `br_offset`, `jal_offset` and `upper_imm`; 0 for every other type.
- `out_misaligned`  out  1  asserted when `HasC == 0`, the type is `br_offset` or `jal_offset`, and `out_target[1] == 1`.
- `out_pc`  out  Width  registered copy of `in_pc`.

## Operation
- Immediate extraction. Sign extension is always from `op[31]` to `Width`.
  - `alu_imm`, `load_offset`, `jalr_offset`: `op[31:20]`.
  - `store_offset`: `{op[31:25], op[11:7]}`.
  - `br_offset`: `{op[31], op[7], op[30:25], op[11:8], 0}`.
  - `jal_offset`: `{op[31], op[19:12], op[20], op[30:21], 0}`.
  - `upper_imm`: `{op[31:12], 12'b0}`.
  - `uimm`: `op[19:15]`, zero-extended.
  - `shamt`: `op[24:20]` when `Width == 32`, `op[25:20]` when `Width == 64`; zero-extended.
  - Any other encoding: imm = 0, target = 0, misaligned = 0.
- Target arithmetic: Width-bit add, wraps modulo 2^Width, no overflow flag.
- All decode and the add are computed combinationally from the input. The results are captured into the main output register on accept.
- Buffering, main register M plus skid register S:
  - `in_ready` is a registered signal equal to `!S.valid`.
  - Accept while M is empty, or while M drains this cycle: load M.
  - Accept while M is full and stalled: load S.
  - When M drains and S is valid: S moves into M and S clears.
  - `out_valid = M.valid`. Outputs are driven directly from M.
- Order is strictly preserved. No payload is dropped or duplicated.
- Payload is held stable while `out_valid && !out_ready`.

## Timing
- Latency: an input accepted at cycle N is visible on the outputs at N+1 when M was empty or draining.
- Throughput is 1 per cycle while `out_ready` stays high.
- After `out_ready` drops, at most 2 instructions are held. `in_ready` falls the cycle after S fills.
- `in_ready` rises the cycle after S drains into M.
- Reset, when `rst_n == 0` at a clock edge:
  - M.valid = 0 and S.valid = 0, so `out_valid = 0`.
  - `in_ready = 1` from the first edge after reset deassertion. It is 0 while reset is held.
  - `out_imm`, `out_target`, `out_pc` and `out_misaligned` = 0.
- Reset mid-transfer discards all buffered entries. Nothing is replayed.
- Simultaneous accept and drain with S empty: M is replaced by the new payload and `out_valid` stays 1.
- Simultaneous accept and drain with S full cannot occur, because `in_ready = 0` in that case.

## Test plan
- Width=32, `alu_imm`, op 0xFFF00093 -> `out_imm` 0xFFFFFFFF one cycle later, target 0, misaligned 0.
- Width=32, `jal_offset`, op 0x0080006F, pc 0x100 -> imm 0x8, target 0x108.
- Width=32, `br_offset`, op 0xFE000EE3, pc 0x200 -> imm 0xFFFFFFFC, target 0x1FC.
- Width=64, `upper_imm`:
  - op 0x800000B7 -> imm 0xFFFFFFFF80000000.
  - op 0x03F09093 as `shamt` -> imm 63.
- HasC=0, `jal_offset`, op 0x0020006F, pc 0x100 -> target 0x102, `out_misaligned` 1.
  - HasC=1 with the same stimulus -> `out_misaligned` 0.
- Back-pressure: stream ops A, B, C, D with `out_ready` held 0 for 3 cycles.
  - A is in M and B is in S; `in_ready` deasserts.
  - When `out_ready` is released: A, B, C, D emerge in order, with no loss or duplication.
  - Assert `rst_n = 0` mid-stream -> `out_valid` is 0 the next cycle and the buffer is empty.
